sat_accum: RTL and testbench

Parametrised, pipelined signed saturating adder/subtractor/accumulator. It is the W-bit successor of the team's 4-bit saturating adder: it adds subtract and accumulate modes, valid/ready flow control, a sticky overflow flag and a two-stage pipeline. It sits between operand sources and result consumers in the datapath lab designs.

---
 rtl/sat_accum_if.sv | 28 ++
 rtl/sat_accum.sv | 132 +++++++++++++
 tb/tb_sat_accum.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sat_accum_if.sv
// Operand/result handshake bundle for sat_accum.
// master = operand source / result consumer side, slave = sat_accum.
interface sat_accum_if #(
  parameter int unsigned W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         ovf_sticky;

  modport master (
    output in_valid, mode, a, b, cin, out_ready,
    input  in_ready, out_valid, result, cout, ovf, ovf_sticky
  );

  modport slave (
    input  in_valid, mode, a, b, cin, out_ready,
    output in_ready, out_valid, result, cout, ovf, ovf_sticky
  );
endinterface

// File: rtl/sat_accum.sv
// Two-stage signed saturating add/sub/accumulate with valid/ready flow control.
// Build option: define SAT_ACCUM_SATURATE_EN to saturate on overflow;
// without it the result (and the accumulator) wraps.
module sat_accum #(
  parameter int unsigned W = 4
) (
  input  logic        clk,
  input  logic        rst,
  sat_accum_if.slave  bus
);
  localparam int unsigned WF = W + 1;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ACC = 2'b10;
  localparam logic [1:0] MODE_CLR = 2'b11;

  logic         adv;

  logic         s1_valid;
  logic [1:0]   s1_mode;
  logic [W-1:0] s1_a;
  logic [W-1:0] s1_b;
  logic         s1_cin;

  logic [W-1:0] acc;
  logic         out_valid;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         ovf_sticky;

  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         c;
  logic [W:0]   sum;
  logic         carry_msb;
  logic         cout_n;
  logic         ovf_n;
  logic [W-1:0] res_n;

  // Whole pipeline advances together whenever the output slot is free or drained
  assign adv          = ~out_valid | bus.out_ready;
  assign bus.in_ready = adv;

  assign bus.out_valid  = out_valid;
  assign bus.result     = result;
  assign bus.cout       = cout;
  assign bus.ovf        = ovf;
  assign bus.ovf_sticky = ovf_sticky;

  // Stage 1: capture the operand beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= MODE_ADD;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cin   <= 1'b0;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_mode <= bus.mode;
        s1_a    <= bus.a;
        s1_b    <= bus.b;
        s1_cin  <= bus.cin;
      end
    end
  end

  // Adder operand steering; SUB uses a + ~b + ~cin = a - b - cin
  always_comb begin
    x = s1_a;
    y = s1_b;
    c = s1_cin;
    case (s1_mode)
      MODE_SUB: begin
        y = ~s1_b;
        c = ~s1_cin;
      end
      MODE_ACC: begin
        x = acc;
        y = s1_a;
      end
      default: ;
    endcase
  end

  // Single W-bit adder with carry out; carry into the MSB recovered from the sum bit
  always_comb begin
    sum       = {1'b0, x} + {1'b0, y} + WF'(c);
    cout_n    = sum[W];
    carry_msb = sum[W-1] ^ x[W-1] ^ y[W-1];
    ovf_n     = carry_msb ^ cout_n;
`ifdef SAT_ACCUM_SATURATE_EN
    res_n     = ovf_n ? {x[W-1], {(W-1){~x[W-1]}}} : sum[W-1:0];
`else
    res_n     = sum[W-1:0];
`endif
  end

  // Stage 2: register the result, update accumulator and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      result     <= '0;
      cout       <= 1'b0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
      acc        <= '0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        if (s1_mode == MODE_CLR) begin
          result     <= '0;
          cout       <= 1'b0;
          ovf        <= 1'b0;
          ovf_sticky <= 1'b0;
          acc        <= '0;
        end else begin
          result     <= res_n;
          cout       <= cout_n;
          ovf        <= ovf_n;
          ovf_sticky <= ovf_sticky | ovf_n;
          if (s1_mode == MODE_ACC) begin
            acc <= res_n;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_sat_accum.sv
// Directed self-checking bench for sat_accum at W=4.
// Expected values follow whichever build (saturating or wrapping) is compiled.
module tb_sat_accum;
  localparam int unsigned W = 4;
`ifdef SAT_ACCUM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] ACC = 2'b10;
  localparam logic [1:0] CLR = 2'b11;

  logic clk = 1'b0;
  logic rst;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sat_accum_if #(.W(W)) bus ();

  sat_accum #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic ci);
    bus.in_valid = v;
    bus.mode     = m;
    bus.a        = x;
    bus.b        = y;
    bus.cin      = ci;
  endtask

  task automatic idle();
    drive(1'b0, ADD, '0, '0, 1'b0);
  endtask

  // Check a valid output beat
  task automatic beat(input string tag, input logic [W-1:0] r, input logic o,
                      input logic co, input logic st);
    check({tag, ".valid"},  32'(bus.out_valid),  32'(1'b1));
    check({tag, ".result"}, 32'(bus.result),     32'(r));
    check({tag, ".ovf"},    32'(bus.ovf),        32'(o));
    check({tag, ".cout"},   32'(bus.cout),       32'(co));
    check({tag, ".sticky"}, 32'(bus.ovf_sticky), 32'(st));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    idle();
    #1;
    check("rst.valid",  32'(bus.out_valid),  32'h0);
    check("rst.result", 32'(bus.result),     32'h0);
    check("rst.sticky", 32'(bus.ovf_sticky), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst.in_ready", 32'(bus.in_ready), 32'h1);

    // Positive overflow, two register stages
    drive(1'b1, ADD, 4'h7, 4'h1, 1'b0);
    tick();
    check("pos.lat", 32'(bus.out_valid), 32'h0);
    idle();
    tick();
    beat("pos", SAT ? 4'h7 : 4'h8, 1'b1, 1'b0, 1'b1);
    tick();
    check("pos.bubble", 32'(bus.out_valid), 32'h0);

    // Negative overflow, then SUB 3-5
    drive(1'b1, ADD, 4'h8, 4'hF, 1'b0);
    tick();
    drive(1'b1, SUB, 4'h3, 4'h5, 1'b0);
    tick();
    beat("neg", SAT ? 4'h8 : 4'h7, 1'b1, 1'b1, 1'b1);
    idle();
    tick();
    beat("sub", 4'hE, 1'b0, 1'b0, 1'b1);

    // Wrap boundary: -8 - 0 - cin
    drive(1'b1, SUB, 4'h8, 4'h0, 1'b0);
    tick();
    drive(1'b1, SUB, 4'h8, 4'h0, 1'b1);
    tick();
    beat("wrap0", 4'h8, 1'b0, 1'b1, 1'b1);
    idle();
    tick();
    beat("wrap1", SAT ? 4'h8 : 4'h7, 1'b1, 1'b1, 1'b1);

    // Accumulate then clear
    drive(1'b1, CLR, 4'h0, 4'h0, 1'b0);
    tick();
    drive(1'b1, ACC, 4'h3, 4'h0, 1'b0);
    tick();
    beat("clr0", 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    beat("acc1", 4'h3, 1'b0, 1'b0, 1'b0);
    tick();
    beat("acc2", 4'h6, 1'b0, 1'b0, 1'b0);
    tick();
    beat("acc3", SAT ? 4'h7 : 4'h9, 1'b1, 1'b0, 1'b1);
    drive(1'b1, ACC, 4'h0, 4'h0, 1'b0);
    tick();
    beat("acc4", SAT ? 4'h7 : 4'hC, SAT, 1'b0, 1'b1);
    drive(1'b1, CLR, 4'h0, 4'h0, 1'b0);
    tick();
    beat("accrd", SAT ? 4'h7 : 4'hC, 1'b0, 1'b0, 1'b1);
    drive(1'b1, ACC, 4'h7, 4'h0, 1'b0);
    tick();
    beat("clr1", 4'h0, 1'b0, 1'b0, 1'b0);

    // CLR directly behind an overflowing ACC
    tick();
    beat("acc7", 4'h7, 1'b0, 1'b0, 1'b0);
    drive(1'b1, CLR, 4'h0, 4'h0, 1'b0);
    tick();
    beat("acc14", SAT ? 4'h7 : 4'hE, 1'b1, 1'b0, 1'b1);
    idle();
    tick();
    beat("clr2", 4'h0, 1'b0, 1'b0, 1'b0);

    // Backpressure with two beats in flight
    drive(1'b1, ADD, 4'h1, 4'h2, 1'b0);
    tick();
    drive(1'b1, ADD, 4'h2, 4'h2, 1'b0);
    tick();
    drive(1'b1, ADD, 4'h3, 4'h3, 1'b0);
    bus.out_ready = 1'b0;
    #1;
    check("bp.in_ready", 32'(bus.in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      beat("bp.hold", 4'h3, 1'b0, 1'b0, 1'b0);
      check("bp.in_ready_h", 32'(bus.in_ready), 32'h0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp.release", 32'(bus.in_ready), 32'h1);
    tick();
    beat("bp.b2", 4'h4, 1'b0, 1'b0, 1'b0);
    idle();
    tick();
    beat("bp.b3", 4'h6, 1'b0, 1'b0, 1'b0);
    tick();
    check("bp.drain", 32'(bus.out_valid), 32'h0);

    // Reset mid-operation: acc=5, sticky set, beats in flight
    drive(1'b1, CLR, 4'h0, 4'h0, 1'b0);
    tick();
    drive(1'b1, ACC, 4'h5, 4'h0, 1'b0);
    tick();
    drive(1'b1, ADD, 4'h7, 4'h1, 1'b0);
    tick();
    drive(1'b1, ACC, 4'h1, 4'h0, 1'b0);
    tick();
    beat("pre_rst", SAT ? 4'h7 : 4'h8, 1'b1, 1'b0, 1'b1);
    idle();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst.valid",  32'(bus.out_valid),  32'h0);
    check("mid_rst.result", 32'(bus.result),     32'h0);
    check("mid_rst.sticky", 32'(bus.ovf_sticky), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst.v0", 32'(bus.out_valid), 32'h0);
    drive(1'b1, ACC, 4'h0, 4'h0, 1'b0);
    tick();
    check("post_rst.v1", 32'(bus.out_valid), 32'h0);
    idle();
    tick();
    beat("post_rst.acc", 4'h0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
